// File: rtl/sized_queue_if.sv
//------------------------------------------------------------------------------
// Module : sized_queue_if
// Brief  : Handshake/status bundle between a sized_queue and its producer
//          and consumer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sized_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push_valid;
    logic [WIDTH-1:0] push_data;
    logic             push_ready;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_data;
    logic             pop_ready;
    logic             clear;
    logic [CW-1:0]    size;
    logic             full;
    logic             empty;
    logic [CW-1:0]    peak_size;

    // Producer/consumer side
    modport master (
        output push_valid, push_data, pop_ready, clear,
        input  push_ready, pop_valid, pop_data, size, full, empty, peak_size
    );

    // Queue side
    modport slave (
        input  push_valid, push_data, pop_ready, clear,
        output push_ready, pop_valid, pop_data, size, full, empty, peak_size
    );
endinterface

`default_nettype wire

// File: rtl/sized_queue.sv
//------------------------------------------------------------------------------
// Module : sized_queue
// Brief  : Bounded FIFO queue (push_back/pop_front/delete/size) with
//          show-ahead output; optional high-water mark via SIZED_QUEUE_PEAK_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sized_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  wire            clk,
    input  wire            rst_n,
    sized_queue_if.slave   q
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_depth    = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    // Explicit wrap so non-power-of-two depths work
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == c_last_ptr) ? '0 : ptr + PW'(1);
    endfunction

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);
    assign w_push  = q.push_valid && !w_full;
    assign w_pop   = q.pop_ready && !w_empty;

    always_comb begin
        w_count_nxt  = r_count;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (q.clear) begin
            w_count_nxt  = '0;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            if (w_push) w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
            if (w_pop)  w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_count  <= w_count_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    // Storage is not reset or scrubbed; only the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push && !q.clear) begin
            r_mem[r_wr_ptr] <= q.push_data;
        end
    end

    assign q.push_ready = !w_full;
    assign q.pop_valid  = !w_empty;
    assign q.pop_data   = r_mem[r_rd_ptr];
    assign q.size       = r_count;
    assign q.full       = w_full;
    assign q.empty      = w_empty;

`ifdef SIZED_QUEUE_PEAK_EN
    logic [CW-1:0] r_peak;

    // Lifetime high-water mark: survives clear, only reset restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak <= '0;
        end else if (w_count_nxt > r_peak) begin
            r_peak <= w_count_nxt;
        end
    end

    assign q.peak_size = r_peak;
`else
    assign q.peak_size = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sized_queue.sv
//------------------------------------------------------------------------------
// Module : tb_sized_queue
// Brief  : Directed self-checking bench for sized_queue (WIDTH=32, DEPTH=8).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sized_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
`ifdef SIZED_QUEUE_PEAK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sized_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) qi ();

    sized_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (qi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] d);
        qi.push_valid = 1'b1;
        qi.push_data  = d;
        tick();
        qi.push_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({qi.size, qi.empty, qi.full, qi.push_ready, qi.pop_valid} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_flags: got size=%0d empty=%b full=%b pr=%b pv=%b, want 0 1 0 1 0",
                     qi.size, qi.empty, qi.full, qi.push_ready, qi.pop_valid);
        end
        total++;
        if (qi.peak_size !== 4'd0) begin
            bad++;
            $display("FAIL reset_peak: got %0d want 0", qi.peak_size);
        end
    endtask

    task automatic test_peak();
        logic [3:0] exp_peak;
        exp_peak = PEAK_ON ? 4'd5 : 4'd0;
        for (int i = 0; i < 5; i++) push_one(32'(300 + i));
        qi.pop_ready = 1'b1;
        repeat (5) tick();
        qi.pop_ready = 1'b0;
        qi.clear = 1'b1;
        tick();
        qi.clear = 1'b0;
        total++;
        if ({qi.peak_size, qi.size} !== {exp_peak, 4'd0}) begin
            bad++;
            $display("FAIL peak_after_clear: got peak=%0d size=%0d want peak=%0d size=0",
                     qi.peak_size, qi.size, exp_peak);
        end
    endtask

    task automatic test_push_basic();
        for (int i = 1; i <= 3; i++) push_one(32'(i));
        total++;
        if ({qi.size, qi.pop_data, qi.empty} !== {4'd3, 32'd1, 1'b0}) begin
            bad++;
            $display("FAIL basic_push: got size=%0d data=%0d empty=%b want 3 1 0",
                     qi.size, qi.pop_data, qi.empty);
        end
        qi.pop_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            total++;
            if (!qi.pop_valid || qi.pop_data !== 32'(i)) begin
                bad++;
                $display("FAIL basic_pop%0d: got valid=%b data=%0d want %0d", i, qi.pop_valid, qi.pop_data, i);
            end
            tick();
        end
        qi.pop_ready = 1'b0;
        total++;
        if ({qi.size, qi.empty} !== {4'd0, 1'b1}) begin
            bad++;
            $display("FAIL basic_drained: got size=%0d empty=%b want 0 1", qi.size, qi.empty);
        end
    endtask

    task automatic test_full();
        logic [3:0] exp_peak;
        exp_peak = PEAK_ON ? 4'd8 : 4'd0;
        for (int i = 0; i < 8; i++) push_one(32'(10 + i));
        total++;
        if ({qi.full, qi.push_ready, qi.size} !== {1'b1, 1'b0, 4'd8}) begin
            bad++;
            $display("FAIL full_flags: got full=%b pr=%b size=%0d want 1 0 8", qi.full, qi.push_ready, qi.size);
        end
        push_one(32'd99);
        total++;
        if ({qi.full, qi.size} !== {1'b1, 4'd8}) begin
            bad++;
            $display("FAIL full_overflow: got full=%b size=%0d want 1 8", qi.full, qi.size);
        end
        total++;
        if (qi.peak_size !== exp_peak) begin
            bad++;
            $display("FAIL full_peak: got %0d want %0d", qi.peak_size, exp_peak);
        end
        // pop from full while a push is still offered: only the pop may fire
        qi.push_valid = 1'b1;
        qi.push_data  = 32'd98;
        qi.pop_ready  = 1'b1;
        total++;
        if (!qi.pop_valid || qi.pop_data !== 32'd10) begin
            bad++;
            $display("FAIL full_pop0: got valid=%b data=%0d want 10", qi.pop_valid, qi.pop_data);
        end
        tick();
        qi.push_valid = 1'b0;
        total++;
        if (qi.size !== 4'd7) begin
            bad++;
            $display("FAIL full_pop_size: got %0d want 7", qi.size);
        end
        for (int i = 1; i < 8; i++) begin
            total++;
            if (!qi.pop_valid || qi.pop_data !== 32'(10 + i)) begin
                bad++;
                $display("FAIL full_drain%0d: got valid=%b data=%0d want %0d", i, qi.pop_valid, qi.pop_data, 10 + i);
            end
            tick();
        end
        qi.pop_ready = 1'b0;
        total++;
        if ({qi.empty, qi.pop_valid} !== {1'b1, 1'b0}) begin
            bad++;
            $display("FAIL full_empty_after: got empty=%b pv=%b want 1 0", qi.empty, qi.pop_valid);
        end
    endtask

    task automatic test_empty_no_fallthrough();
        qi.push_valid = 1'b1;
        qi.push_data  = 32'd42;
        qi.pop_ready  = 1'b1;
        tick();
        qi.push_valid = 1'b0;
        qi.pop_ready  = 1'b0;
        total++;
        if ({qi.size, qi.pop_data} !== {4'd1, 32'd42}) begin
            bad++;
            $display("FAIL empty_push_pop: got size=%0d data=%0d want 1 42", qi.size, qi.pop_data);
        end
        qi.pop_ready = 1'b1;
        tick();
        qi.pop_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) push_one(32'(100 + i));
        qi.push_valid = 1'b1;
        qi.pop_ready  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            qi.push_data = 32'(104 + i);
            total++;
            if (!qi.pop_valid || qi.pop_data !== 32'(100 + i)) begin
                bad++;
                $display("FAIL b2b_data%0d: got valid=%b data=%0d want %0d", i, qi.pop_valid, qi.pop_data, 100 + i);
            end
            tick();
            total++;
            if (qi.size !== 4'd4) begin
                bad++;
                $display("FAIL b2b_size%0d: got %0d want 4", i, qi.size);
            end
        end
        qi.push_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (!qi.pop_valid || qi.pop_data !== 32'(120 + i)) begin
                bad++;
                $display("FAIL b2b_tail%0d: got valid=%b data=%0d want %0d", i, qi.pop_valid, qi.pop_data, 120 + i);
            end
            tick();
        end
        qi.pop_ready = 1'b0;
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) push_one(32'(200 + i));
        qi.clear      = 1'b1;
        qi.push_valid = 1'b1;
        qi.push_data  = 32'd77;
        tick();
        qi.clear      = 1'b0;
        qi.push_valid = 1'b0;
        total++;
        if ({qi.size, qi.empty, qi.pop_valid} !== {4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL clear_state: got size=%0d empty=%b pv=%b want 0 1 0", qi.size, qi.empty, qi.pop_valid);
        end
        push_one(32'd55);
        total++;
        if ({qi.size, qi.pop_data} !== {4'd1, 32'd55}) begin
            bad++;
            $display("FAIL clear_repush: got size=%0d data=%0d want 1 55", qi.size, qi.pop_data);
        end
        qi.pop_ready = 1'b1;
        tick();
        qi.pop_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) push_one(32'(400 + i));
        total++;
        if (qi.size !== 4'd6) begin
            bad++;
            $display("FAIL areset_pre: got size=%0d want 6", qi.size);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({qi.size, qi.pop_valid, qi.empty, qi.peak_size} !== {4'd0, 1'b0, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL areset_now: got size=%0d pv=%b empty=%b peak=%0d want 0 0 1 0",
                     qi.size, qi.pop_valid, qi.empty, qi.peak_size);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        push_one(32'd7);
        total++;
        if ({qi.size, qi.pop_data} !== {4'd1, 32'd7}) begin
            bad++;
            $display("FAIL areset_post: got size=%0d data=%0d want 1 7", qi.size, qi.pop_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        qi.push_valid = 1'b0;
        qi.push_data  = '0;
        qi.pop_ready  = 1'b0;
        qi.clear      = 1'b0;
        #12;
        test_reset();
        tick();
        rst_n = 1'b1;
        test_peak();
        test_push_basic();
        test_full();
        test_empty_no_fallthrough();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/sized_queue.md
# sized_queue

Bounded, synthesizable model of a SystemVerilog queue with `push_back`, `pop_front`, `delete()` and `size()` semantics. It is the upstream producer stage for the array-size checking blocks: it holds elements in a circular buffer and publishes a registered element count that downstream logic compares against expected `size()` results. Elements leave in first-in, first-out order with show-ahead output.

## Interface
Parameters:
- `WIDTH`, 32, element width in bits (≥1).
- `DEPTH`, 8, capacity in elements (≥2; need not be a power of two).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`, input, 1, rising-edge clock.
  - `rst_n`, input, 1, asynchronous active-low reset.
- `push_valid`, input, 1, element offered (`push_back`).
- `push_data`, input, WIDTH, element value.
- `push_ready`, output, 1, queue can accept an element this cycle.
- `pop_valid`, output, 1, head element available.
- `pop_data`, output, WIDTH, head element (show-ahead).
- `pop_ready`, input, 1, consumer takes the head (`pop_front`).
- `clear`, input, 1, discard all contents (`delete()`).
- `size`, output, $clog2(DEPTH+1), current element count.
- `full`, output, 1, size == DEPTH.
- `empty`, output, 1, size == 0.
- `peak_size`, output, $clog2(DEPTH+1), high-water mark (see Configuration).

## Operation
- Storage: DEPTH×WIDTH array, write pointer `wr_ptr`, read pointer `rd_ptr`, counter `count`. All three are registered.
- `push_ready` = !full. `pop_valid` = !empty. `pop_data` = mem[rd_ptr], combinational from state.
- Push fires when push_valid && push_ready. Data is written at wr_ptr, and wr_ptr advances.
- Pop fires when pop_valid && pop_ready. rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. This uses an explicit compare, not modulo power of two.
- Count update per cycle:
  - push only: +1.
  - pop only: −1.
  - both fire: unchanged, and both pointers advance.
- Full with pop_ready=1: the pop fires. The push does not fire because push_ready=0. Count decrements.
- Empty with push_valid=1 and pop_ready=1: only the push fires. There is no fall-through within the same cycle.
- `clear` has priority over everything in its cycle:
  - wr_ptr, rd_ptr and count go to 0.
  - A push or pop offered in the same cycle is ignored.
  - Memory contents are not scrubbed.
- `pop_data` while empty is don't-care. The bench checks it only when pop_valid=1.
- Under-/overflow is impossible by construction. The counter never leaves 0..DEPTH.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert assumed by the system):
  - count=0, wr_ptr=0, rd_ptr=0, peak_size=0.
  - Hence size=0, empty=1, full=0, push_ready=1, pop_valid=0.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- size, full and empty reflect handshakes one cycle after the edge on which they fire.
- Push-to-pop latency: an element pushed at edge N is visible on pop_data with pop_valid=1 after edge N, so it can be popped at edge N+1.
- clear at edge N: size=0 and empty=1 after edge N.
- Sustained throughput is one push and one pop per cycle when 0 < size < DEPTH.

## Configuration
- Macro: `SIZED_QUEUE_PEAK_EN`.
- Defined:
  - peak_size is a register updated each cycle to max(peak_size, next count).
  - It resets to 0 on rst_n.
  - It is not cleared by `clear`, because it records the lifetime high-water mark.
- Undefined: peak_size is tied to 0 and no register is inferred.

## Test plan
- Reset, then push 1, 2, 3 on consecutive cycles with pop_ready=0 -> size=3, pop_data=1, empty=0.
- Fill DEPTH=8 with 10..17, then assert push_valid=1 and push_data=99 -> full=1, push_ready=0, size stays 8, and popping drains 10..17 in order.
- Simultaneous push and pop at size 4 for 20 cycles -> size holds at 4, pointers wrap past 7→0, and order is preserved.
- Push 5 elements, then assert clear together with push_valid=1 -> next cycle size=0, empty=1, and the pushed element is dropped.
- Assert rst_n low at size 6 between clock edges -> size=0 and pop_valid=0 before the next edge.
- With `SIZED_QUEUE_PEAK_EN`: push 5, pop 5, clear -> peak_size=5 and size=0. Without the macro, peak_size=0 throughout.
